// File: rtl/framebuffer_axi_pkg.sv
// rtl/framebuffer_axi_pkg.sv - shared types and constants for the framebuffer AXI write master
package framebuffer_axi_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;

  function automatic logic [2:0] axi_size(input int strb_width);
    logic [2:0] sz;
    sz = '0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == strb_width) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/framebuffer_burst_len_calc.sv
// rtl/framebuffer_burst_len_calc.sv - burst length = min(remaining, MAX_BURST_LEN, beats to next 4 KiB page)
module framebuffer_burst_len_calc
  import framebuffer_axi_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int AWSIZE        = 2
) (
  input  logic [11:0]           addr_i,
  input  logic [ADDR_WIDTH-1:0] remaining_i,
  output logic [7:0]            awlen_o
);

  localparam logic [12:0] BOUNDARY = 13'(BOUNDARY_4K);

  logic [12:0]           to_boundary;
  logic [ADDR_WIDTH-1:0] len;

  always_comb begin
    to_boundary = (BOUNDARY - {1'b0, addr_i}) >> AWSIZE;
    len = remaining_i;
    if (len > ADDR_WIDTH'(MAX_BURST_LEN)) len = ADDR_WIDTH'(MAX_BURST_LEN);
    if (len > ADDR_WIDTH'(to_boundary))   len = ADDR_WIDTH'(to_boundary);
    awlen_o = 8'(len - ADDR_WIDTH'(1));
  end

endmodule

// File: rtl/framebuffer_axi_write_master.sv
// rtl/framebuffer_axi_write_master.sv - framebuffer stream to AXI4 INCR write bursts, one burst outstanding
// Optional tlast consistency check: FB_AXI_TLAST_CHECK_EN.
module framebuffer_axi_write_master
  import framebuffer_axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_avalid,
  output logic                  s_aready,
  input  logic [ADDR_WIDTH-1:0] s_aaddr,
  input  logic [ADDR_WIDTH-1:0] s_abeats,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s_axis_tstrb,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  busy,
  output logic                  error
);

  localparam logic [2:0]            AWSIZE    = axi_size(STRB_WIDTH);
  localparam int                    SZ        = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [7:0]            beat_q, beat_d;
  logic                  error_q, error_d;

  logic                  accept, aw_hs, w_hs, b_hs;
  logic [ADDR_WIDTH-1:0] burst_beats, addr_next, rem_next, calc_rem;
  logic [11:0]           calc_addr;
  logic [7:0]            calc_awlen;

  assign accept      = (state_q == IDLE) && s_avalid && (s_abeats != '0);
  assign aw_hs       = (state_q == ADDR) && m_axi_awready;
  assign w_hs        = m_axi_wvalid && m_axi_wready;
  assign b_hs        = (state_q == RESP) && m_axi_bvalid;
  assign burst_beats = ADDR_WIDTH'(awlen_q) + ADDR_WIDTH'(1);
  assign addr_next   = addr_q + (burst_beats << SZ);
  assign rem_next    = remaining_q - burst_beats;

  // Length of the next burst is computed from whatever address/count is about to be loaded.
  assign calc_addr = (state_q == IDLE) ? (s_aaddr[11:0] & ADDR_MASK[11:0]) : addr_next[11:0];
  assign calc_rem  = (state_q == IDLE) ? s_abeats : rem_next;

  framebuffer_burst_len_calc #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN),
    .AWSIZE       (SZ)
  ) u_len_calc (
    .addr_i     (calc_addr),
    .remaining_i(calc_rem),
    .awlen_o    (calc_awlen)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ADDR;
      ADDR:    if (m_axi_awready) state_d = DATA;
      DATA:    if (w_hs && m_axi_wlast) state_d = RESP;
      RESP:    if (m_axi_bvalid) state_d = (rem_next != '0) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_aready      = 1'b0;
    busy          = 1'b1;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    s_axis_tready = 1'b0;
    m_axi_bready  = 1'b0;
    case (state_q)
      IDLE: begin
        s_aready = 1'b1;
        busy     = 1'b0;
      end
      ADDR: m_axi_awvalid = 1'b1;
      DATA: begin
        m_axi_wvalid  = s_axis_tvalid;
        s_axis_tready = m_axi_wready;
        m_axi_wlast   = (beat_q == awlen_q);
      end
      RESP:    m_axi_bready = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = AWSIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = s_axis_tstrb;
  assign error         = error_q;

  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    awlen_d     = awlen_q;
    beat_d      = beat_q;
    error_d     = error_q;
    if (accept) begin
      addr_d      = s_aaddr & ADDR_MASK;
      remaining_d = s_abeats;
      awlen_d     = calc_awlen;
      error_d     = 1'b0;
    end
    if (aw_hs) beat_d = 8'd0;
    if (w_hs)  beat_d = beat_q + 8'd1;
`ifdef FB_AXI_TLAST_CHECK_EN
    // tlast must mark exactly the final beat of the whole commit.
    if (w_hs && (s_axis_tlast != ((remaining_q == burst_beats) && m_axi_wlast))) error_d = 1'b1;
`endif
    if (b_hs) begin
      addr_d      = addr_next;
      remaining_d = rem_next;
      awlen_d     = calc_awlen;
      if (m_axi_bresp != AXI_RESP_OKAY) error_d = 1'b1;
    end
  end

`ifndef FB_AXI_TLAST_CHECK_EN
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      awlen_q     <= '0;
      beat_q      <= '0;
      error_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      awlen_q     <= awlen_d;
      beat_q      <= beat_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_framebuffer_axi_write_master.sv
// tb/tb_framebuffer_axi_write_master.sv - self-checking bench for framebuffer_axi_write_master
module tb_framebuffer_axi_write_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_avalid, s_aready;
  logic [31:0] s_aaddr, s_abeats;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tstrb;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        busy, error;

  always #5 clk = ~clk;

  framebuffer_axi_write_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST_LEN(16)
  ) dut (
    .clk(clk), .reset(reset),
    .s_avalid(s_avalid), .s_aready(s_aready), .s_aaddr(s_aaddr), .s_abeats(s_abeats),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .busy(busy), .error(error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] beats;
    bit          rnd;
    int          err_burst;
    int          exp_bursts;
    bit          exp_err;
    bit          chk_err;
  } vec_t;

  typedef struct { logic [31:0] a; logic [7:0] l; } aw_t;
  typedef struct { logic [31:0] d; logic [3:0] s; logic l; } w_t;

  vec_t vecs[7];
  aw_t  aw_q[$], m_q[$];
  w_t   w_q[$], src_q[$];
  bit   exp_last[$];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    s_avalid      = 1'b0;
    s_aaddr       = '0;
    s_abeats      = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
  endtask

  // Reference: split [addr, addr+beats*4) into bursts of <=16 beats that never cross a 4 KiB page.
  task automatic build_model(input logic [31:0] addr, input logic [31:0] beats);
    logic [31:0] a;
    int r, len, room;
    m_q.delete();
    exp_last.delete();
    a = addr & 32'hFFFF_FFFC;
    r = int'(beats);
    while (r > 0) begin
      len  = (r < 16) ? r : 16;
      room = (4096 - int'(a[11:0])) / 4;
      if (len > room) len = room;
      m_q.push_back('{a, 8'(len - 1)});
      for (int i = 0; i < len; i++) exp_last.push_back(i == len - 1);
      a = a + 32'(len * 4);
      r = r - len;
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int src_idx, b_cnt, oob;
    bit took, wl_done, b_done, b_pending, done;
    src_idx = 0; b_cnt = 0; oob = 0;
    took = 0; wl_done = 0; b_done = 0; b_pending = 0; done = 0;
    aw_q.delete();
    w_q.delete();
    src_q.delete();
    build_model(v.addr, v.beats);
    for (int i = 0; i < int'(v.beats); i++)
      src_q.push_back('{$urandom, 4'($urandom_range(0, 15)), 1'b0});

    @(negedge clk);
    s_avalid = 1'b1;
    s_aaddr  = v.addr;
    s_abeats = v.beats;
    #1 check("aready_idle", longint'(s_aready), 1);
    @(negedge clk);
    s_avalid = 1'b0;
    #1;
    if (v.beats != 0) check("error_cleared_on_accept", longint'(error), 0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (took)    begin src_idx++; s_axis_tvalid = 1'b0; took = 0; end
      if (wl_done) begin b_pending = 1; wl_done = 0; end
      if (b_done)  begin b_pending = 0; b_cnt++; b_done = 0; end
      if (b_cnt == m_q.size() && (m_q.size() != 0 || cyc >= 8)) begin
        check("busy_after_last_b", longint'(busy), 0);
        check("aready_after_last_b", longint'(s_aready), 1);
        done = 1;
        break;
      end
      m_axi_awready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!s_axis_tvalid && src_idx < int'(v.beats) && (!v.rnd || $urandom_range(0, 1) == 1)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = src_q[src_idx].d;
        s_axis_tstrb  = src_q[src_idx].s;
        s_axis_tlast  = (src_idx == int'(v.beats) - 1);
      end
      m_axi_bvalid = b_pending && (!v.rnd || $urandom_range(0, 1) == 1);
      m_axi_bresp  = (b_cnt == v.err_burst) ? 2'b10 : 2'b00;
      #1;
      if ((s_axis_tready || m_axi_wvalid) && !(busy && !m_axi_awvalid && !m_axi_bready)) oob++;
      if (m_axi_awvalid && m_axi_awready) aw_q.push_back('{m_axi_awaddr, m_axi_awlen});
      if (m_axi_wvalid && m_axi_wready) begin
        w_q.push_back('{m_axi_wdata, m_axi_wstrb, m_axi_wlast});
        if (m_axi_wlast) wl_done = 1;
      end
      if (s_axis_tvalid && s_axis_tready) took = 1;
      if (m_axi_bvalid && m_axi_bready) b_done = 1;
    end
    if (!done) check("xfer_timeout", 0, 1);
    idle_inputs();

    if (v.exp_bursts >= 0) check("aw_count_table", longint'(aw_q.size()), longint'(v.exp_bursts));
    check("aw_count_model", longint'(aw_q.size()), longint'(m_q.size()));
    for (int i = 0; i < aw_q.size() && i < m_q.size(); i++) begin
      check($sformatf("awaddr[%0d]", i), longint'(aw_q[i].a), longint'(m_q[i].a));
      check($sformatf("awlen[%0d]", i), longint'(aw_q[i].l), longint'(m_q[i].l));
    end
    check("w_count", longint'(w_q.size()), longint'(v.beats));
    for (int i = 0; i < w_q.size() && i < src_q.size(); i++) begin
      check($sformatf("wdata[%0d]", i), longint'(w_q[i].d), longint'(src_q[i].d));
      check($sformatf("wstrb[%0d]", i), longint'(w_q[i].s), longint'(src_q[i].s));
      check($sformatf("wlast[%0d]", i), longint'(w_q[i].l), longint'(exp_last[i]));
    end
    check("tready_outside_data", longint'(oob), 0);
    if (v.chk_err) check("error_flag", longint'(error), longint'(v.exp_err));
  endtask

  initial begin
    vec_t rv;
    int   wn;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_aready", longint'(s_aready), 1);
    check("rst_awvalid", longint'(m_axi_awvalid), 0);
    check("rst_wvalid", longint'(m_axi_wvalid), 0);
    check("rst_tready", longint'(s_axis_tready), 0);
    check("rst_bready", longint'(m_axi_bready), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_error", longint'(error), 0);
    check("awsize", longint'(m_axi_awsize), 2);
    check("awburst", longint'(m_axi_awburst), 1);
    reset = 1'b0;

    vecs[0] = '{32'h1000, 32'd16, 1'b0, -1, 1, 1'b0, 1'b1};
    vecs[1] = '{32'h1000, 32'd40, 1'b0, -1, 3, 1'b0, 1'b1};
    vecs[2] = '{32'h1FF8, 32'd8,  1'b0, -1, 2, 1'b0, 1'b1};
    vecs[3] = '{32'h3000, 32'd20, 1'b1, -1, 2, 1'b0, 1'b1};
    vecs[4] = '{32'h5000, 32'd32, 1'b0,  1, 2, 1'b1, 1'b1};
    vecs[5] = '{32'h6000, 32'd0,  1'b0, -1, 0, 1'b0, 1'b0};
    vecs[6] = '{32'h2000, 32'd24, 1'b0, -1, 2, 1'b0, 1'b1};
    for (int t = 0; t < 7; t++) run_xfer(vecs[t]);

    for (int t = 0; t < 4; t++) begin
      rv = '{32'($urandom_range(0, 32'hFFFF)) & 32'hFFFF_FFFC, 32'($urandom_range(1, 50)),
             1'b1, -1, -1, 1'b0, 1'b1};
      run_xfer(rv);
    end

    // Reset in the middle of a burst's data phase.
    @(negedge clk);
    s_avalid = 1'b1; s_aaddr = 32'h4000; s_abeats = 32'd16;
    @(negedge clk);
    s_avalid = 1'b0;
    wn = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (wn == 5) break;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'(cyc); s_axis_tstrb = 4'hF;
      #1;
      if (m_axi_wvalid && m_axi_wready) wn++;
    end
    check("beats_before_reset", longint'(wn), 5);
    reset = 1'b1;
    #1;
    check("midrst_awvalid", longint'(m_axi_awvalid), 0);
    check("midrst_wvalid", longint'(m_axi_wvalid), 0);
    check("midrst_bready", longint'(m_axi_bready), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_aready", longint'(s_aready), 1);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    rv = '{32'h0, 32'd4, 1'b0, -1, 1, 1'b0, 1'b1};
    run_xfer(rv);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/framebuffer_axi_write_master.md
Name: framebuffer_axi_write_master

Overview:
- Downstream neighbour of the internal framebuffer's command handler.
- Consumes the commit request (address and beat count) and the AXI-Stream of framebuffer pixels.
- Emits AXI4 INCR write bursts to external memory, splitting at MAX_BURST_LEN beats and at 4 KiB boundaries.
- Keeps one burst outstanding at a time and reports write-response errors.

Parameters:
- DATA_WIDTH, 32, width of the stream and of the AXI W data; byte multiple, power of two.
- ADDR_WIDTH, 32, width of the byte address and of the beat count.
- MAX_BURST_LEN, 16, maximum beats per AXI burst; power of two, 1..256.
- STRB_WIDTH, DATA_WIDTH/8, localparam, AXI W strobe width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_avalid  in  1  commit request valid.
- s_aready  out  1  request accepted; high only in IDLE.
- s_aaddr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits forced to zero.
- s_abeats  in  ADDR_WIDTH  total beats to write.
- s_axis_tvalid  in  1  pixel stream valid.
- s_axis_tready  out  1  pixel stream ready.
- s_axis_tlast  in  1  stream last.
- s_axis_tdata  in  DATA_WIDTH  pixel data.
- s_axis_tstrb  in  STRB_WIDTH  byte strobes.
- m_axi_awvalid  out  1  AW valid.
- m_axi_awready  in  1  AW ready.
- m_axi_awaddr  out  ADDR_WIDTH  burst address.
- m_axi_awlen  out  8  beats minus 1.
- m_axi_awsize  out  3  log2(STRB_WIDTH).
- m_axi_awburst  out  2  constant 2'b01 (INCR).
- m_axi_wvalid  out  1  W valid.
- m_axi_wready  in  1  W ready.
- m_axi_wdata  out  DATA_WIDTH  write data.
- m_axi_wstrb  out  STRB_WIDTH  write strobes.
- m_axi_wlast  out  1  last beat of burst.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_bresp  in  2  write response.
- busy  out  1  high outside IDLE.
- error  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous): state IDLE; registered outputs zero except s_aready=1. awvalid, wvalid, bready, busy and error are all 0.
- Reset mid-burst abandons any outstanding AXI transaction; the system reset covers the slave side.
- IDLE:
  - s_aready=1.
  - On s_avalid with s_abeats!=0: latch address and remaining count, clear error, go to ADDR.
  - On s_avalid with s_abeats==0: consume the request and stay IDLE.
- Burst length = min(remaining, MAX_BURST_LEN, (4096 - awaddr[11:0]) >> log2(STRB_WIDTH)). It is registered on entry to ADDR.
- ADDR:
  - awvalid=1 with awaddr and awlen stable until awready.
  - On handshake: load the beat counter, go to DATA.
  - awvalid is asserted the cycle after the request is accepted or after the previous B response.
- DATA:
  - Combinational pass-through: wvalid=s_axis_tvalid, s_axis_tready=wready, wdata=tdata, wstrb=tstrb.
  - wlast=1 when the beat counter equals awlen.
  - A beat transfers on wvalid&&wready. The final beat goes to RESP.
  - Outside DATA, s_axis_tready=0 and wvalid=0.
- RESP:
  - bready=1.
  - On bvalid: error|=(bresp!=2'b00). Address advances by beats*STRB_WIDTH and remaining decreases by beats.
  - If remaining!=0 go to ADDR, else go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; there is no overflow check.
- error is sticky until the next request is accepted. It does not abort the transfer.
- Throughput is 1 beat/cycle inside a burst. Each burst adds 2 overhead cycles (ADDR, RESP) minimum.

Optional Feature:
- Macro: FB_AXI_TLAST_CHECK_EN.
- Defined: s_axis_tlast is compared on every transferred beat against (remaining==burst beats && final beat of burst). A mismatch sets error. The beat is still written and the count is not altered.
- Undefined: s_axis_tlast is ignored and error reflects only bresp.

Decomposition:
- Package framebuffer_axi_pkg holds:
  - state enum {IDLE, ADDR, DATA, RESP};
  - AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, BOUNDARY_4K=4096;
  - a function computing awsize from STRB_WIDTH.
- Sub-module framebuffer_burst_len_calc: combinational min() of remaining, MAX_BURST_LEN and beats to the 4 KiB boundary; outputs awlen.

Test Plan:
- aaddr=0x1000, abeats=16, wready=1 → one AW (0x1000, awlen=15); wlast on beat 16; s_aready=1 the cycle after bvalid; error=0.
- aaddr=0x1000, abeats=40 → AW bursts at 0x1000/awlen 15, 0x1040/awlen 15, 0x1080/awlen 7; 40 W beats total, data in order.
- aaddr=0x1FF8, abeats=8 → AW 0x1FF8/awlen 1, then 0x2000/awlen 5; no burst crosses 0x2000.
- abeats=20 with random wready and tvalid gaps (50%) → scoreboard matches all 20 beats; no duplication or loss; tready never high outside DATA.
- abeats=32, bresp=2'b10 on burst 2 → error=1 after that B; both bursts complete; error clears on next accepted request. abeats=0 → consumed, no AW issued.
- Reset asserted in DATA after 5 beats → awvalid/wvalid/bready/busy=0 immediately; after release a new request at 0x0, abeats=4 completes normally.
